// File: rtl/lock_demod_pkg.sv
// Shared widths, FSM state encoding and small arithmetic helpers for the
// lock-in demodulator.
package lock_demod_pkg;

  localparam int SIG_W   = 14;
  localparam int PROD_W  = 28;
  localparam int ACC_W   = 56;
  localparam int CNT_W   = 27;
  localparam int OUT_W   = 32;
  localparam int SHIFT_W = 5;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // Multiply by a +1/-1 square reference, widened to product width so that
  // negating the most negative input cannot wrap.
  function automatic logic signed [PROD_W-1:0] sq_prod(
    input logic signed [SIG_W-1:0] sig,
    input logic                    pos
  );
    logic signed [PROD_W-1:0] ext;
    ext = {{(PROD_W-SIG_W){sig[SIG_W-1]}}, sig};
    if (pos) begin
      return ext;
    end else begin
      return -ext;
    end
  endfunction

  // Full-precision signed product of two input-width operands.
  function automatic logic signed [PROD_W-1:0] mul_prod(
    input logic signed [SIG_W-1:0] a,
    input logic signed [SIG_W-1:0] b
  );
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    a_ext = {{(PROD_W-SIG_W){a[SIG_W-1]}}, a};
    b_ext = {{(PROD_W-SIG_W){b[SIG_W-1]}}, b};
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/lock_demod_sat.sv
// Arithmetic right shift of a window sum followed by clamping to the signed
// output range; flags when clamping happened. Purely combinational, the
// caller registers the result.
module lock_demod_sat
  import lock_demod_pkg::*;
(
  input  logic signed [ACC_W-1:0]   acc,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0]   res,
  output logic                      sat
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = acc >>> shift;

  // Clamp the shifted value into the 32-bit signed range.
  always_comb begin
    res = '0;
    sat = 1'b0;
    if (shifted_s > MAX_V) begin
      res = {1'b0, {(OUT_W-1){1'b1}}};
      sat = 1'b1;
    end else if (shifted_s < MIN_V) begin
      res = {1'b1, {(OUT_W-1){1'b0}}};
      sat = 1'b1;
    end else begin
      res = shifted_s[OUT_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/lock_demod.sv
// Lock-in demodulator: multiplies the input by in-phase and quadrature
// references (harmonic or square), sums the products over one reference
// period delimited by a trigger, and reports scaled, saturated window sums.
// Pipeline: stage 0 input registers, stage 1 products, stage 2 accumulators
// and control FSM. A trigger sampled at edge k is reported at edge k+2.
module lock_demod
  import lock_demod_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      mode,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      clr,
  input  logic signed [SIG_W-1:0]   sig_in,
  input  logic signed [SIG_W-1:0]   cos_ref,
  input  logic signed [SIG_W-1:0]   sin_ref,
  input  logic                      harmonic_trig,
  input  logic                      sq_ref,
  input  logic                      sq_quad,
  input  logic                      square_trig,
  output logic signed [OUT_W-1:0]   x_out,
  output logic signed [OUT_W-1:0]   y_out,
  output logic        [CNT_W-1:0]   n_samp,
  output logic                      valid,
  output logic                      busy,
  output logic                      ovf
);

  // Stage 0: raw input capture.
  logic signed [SIG_W-1:0]  sig0_r;
  logic signed [SIG_W-1:0]  cos0_r;
  logic signed [SIG_W-1:0]  sin0_r;
  logic                     sq0_r;
  logic                     sqq0_r;
  logic                     trig0_r;
  logic                     mode0_r;

  // Stage 1: products and the control bits that travel with them.
  logic signed [PROD_W-1:0] px1_r;
  logic signed [PROD_W-1:0] py1_r;
  logic                     trig1_r;
  logic                     mode1_r;
  logic                     mode_last_r;

  // Stage 2: accumulators, counter and FSM.
  state_t                   state_r;
  logic signed [ACC_W-1:0]  ax_r;
  logic signed [ACC_W-1:0]  ay_r;
  logic        [CNT_W-1:0]  cnt_r;

  logic signed [PROD_W-1:0] px_s;
  logic signed [PROD_W-1:0] py_s;
  logic signed [ACC_W-1:0]  sum_x_s;
  logic signed [ACC_W-1:0]  sum_y_s;
  logic        [CNT_W-1:0]  cnt_inc_s;
  logic                     cnt_sat_s;
  logic                     mode_chg_s;
  logic                     acc_step_s;
  logic                     ovf_set_s;
  logic signed [OUT_W-1:0]  res_x_s;
  logic signed [OUT_W-1:0]  res_y_s;
  logic                     sat_x_s;
  logic                     sat_y_s;

  // Stage 0: register every input sample with the trigger of the active mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig0_r  <= '0;
      cos0_r  <= '0;
      sin0_r  <= '0;
      sq0_r   <= 1'b0;
      sqq0_r  <= 1'b0;
      trig0_r <= 1'b0;
      mode0_r <= 1'b0;
    end else begin
      sig0_r  <= sig_in;
      cos0_r  <= cos_ref;
      sin0_r  <= sin_ref;
      sq0_r   <= sq_ref;
      sqq0_r  <= sq_quad;
      trig0_r <= mode ? square_trig : harmonic_trig;
      mode0_r <= mode;
    end
  end

  // Product selection for the reference type that captured the sample.
  always_comb begin
    px_s = '0;
    py_s = '0;
    if (mode0_r) begin
      px_s = sq_prod(sig0_r, sq0_r);
      py_s = sq_prod(sig0_r, sqq0_r);
    end else begin
      px_s = mul_prod(sig0_r, cos0_r);
      py_s = mul_prod(sig0_r, sin0_r);
    end
  end

  // Stage 1: register products; remember the previous sample's mode so a
  // reference switch is seen exactly on the first sample of the new mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      px1_r       <= '0;
      py1_r       <= '0;
      trig1_r     <= 1'b0;
      mode1_r     <= 1'b0;
      mode_last_r <= 1'b0;
    end else begin
      px1_r       <= px_s;
      py1_r       <= py_s;
      trig1_r     <= trig0_r;
      mode1_r     <= mode0_r;
      mode_last_r <= mode1_r;
    end
  end

  assign sum_x_s    = ax_r + {{(ACC_W-PROD_W){px1_r[PROD_W-1]}}, px1_r};
  assign sum_y_s    = ay_r + {{(ACC_W-PROD_W){py1_r[PROD_W-1]}}, py1_r};
  assign cnt_sat_s  = (cnt_r == CNT_MAX);
  assign cnt_inc_s  = cnt_sat_s ? cnt_r : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
  assign mode_chg_s = (mode1_r != mode_last_r);
  assign acc_step_s = en && (state_r == ACCUM) && !mode_chg_s;
  assign ovf_set_s  = acc_step_s && (cnt_sat_s || (trig1_r && (sat_x_s || sat_y_s)));

  lock_demod_sat u_sat_x (
    .acc   (sum_x_s),
    .shift (shift),
    .res   (res_x_s),
    .sat   (sat_x_s)
  );

  lock_demod_sat u_sat_y (
    .acc   (sum_y_s),
    .shift (shift),
    .res   (res_y_s),
    .sat   (sat_y_s)
  );

  // Window FSM: synchronise to a trigger, accumulate, and publish each window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      ax_r    <= '0;
      ay_r    <= '0;
      cnt_r   <= '0;
      x_out   <= '0;
      y_out   <= '0;
      n_samp  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      valid <= 1'b0;
      ovf   <= ovf_set_s ? 1'b1 : (clr ? 1'b0 : ovf);
      if (!en) begin
        state_r <= IDLE;
        ax_r    <= '0;
        ay_r    <= '0;
        cnt_r   <= '0;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= SYNC;
            ax_r    <= '0;
            ay_r    <= '0;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end
          SYNC: begin
            ax_r  <= '0;
            ay_r  <= '0;
            cnt_r <= '0;
            if (!mode_chg_s && trig1_r) begin
              state_r <= ACCUM;
              busy    <= 1'b1;
            end else begin
              state_r <= SYNC;
              busy    <= 1'b0;
            end
          end
          ACCUM: begin
            if (mode_chg_s) begin
              // Reference switched: this window mixes two references.
              state_r <= SYNC;
              ax_r    <= '0;
              ay_r    <= '0;
              cnt_r   <= '0;
              busy    <= 1'b0;
            end else if (trig1_r) begin
              state_r <= ACCUM;
              x_out   <= res_x_s;
              y_out   <= res_y_s;
              n_samp  <= cnt_inc_s;
              valid   <= 1'b1;
              ax_r    <= '0;
              ay_r    <= '0;
              cnt_r   <= '0;
              busy    <= 1'b1;
            end else begin
              state_r <= ACCUM;
              ax_r    <= sum_x_s;
              ay_r    <= sum_y_s;
              cnt_r   <= cnt_inc_s;
              busy    <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            ax_r    <= '0;
            ay_r    <= '0;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lock_demod.sv
// Self-checking bench for lock_demod: directed scenarios plus random
// stimulus compared every cycle against a sample-level behavioural model.
module tb_lock_demod;

  logic               clk = 1'b0;
  logic               rstn;
  logic               en;
  logic               mode;
  logic [4:0]         shift;
  logic               clr;
  logic signed [13:0] sig_in;
  logic signed [13:0] cos_ref;
  logic signed [13:0] sin_ref;
  logic               harmonic_trig;
  logic               sq_ref;
  logic               sq_quad;
  logic               square_trig;
  logic signed [31:0] x_out;
  logic signed [31:0] y_out;
  logic [26:0]        n_samp;
  logic               valid;
  logic               busy;
  logic               ovf;

  always #5 clk = ~clk;

  lock_demod dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .mode          (mode),
    .shift         (shift),
    .clr           (clr),
    .sig_in        (sig_in),
    .cos_ref       (cos_ref),
    .sin_ref       (sin_ref),
    .harmonic_trig (harmonic_trig),
    .sq_ref        (sq_ref),
    .sq_quad       (sq_quad),
    .square_trig   (square_trig),
    .x_out         (x_out),
    .y_out         (y_out),
    .n_samp        (n_samp),
    .valid         (valid),
    .busy          (busy),
    .ovf           (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dut_valids = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Each sample becomes a (px, py, trig, mode) tuple; the sample entered two
  // edges ago is the one acted on now. Windows are plain integer sums.
  localparam longint CNT_MAX = (64'sd1 <<< 27) - 1;
  longint h_px [4];
  longint h_py [4];
  bit     h_trig [4];
  bit     h_mode [4];
  int     m_state;            // 0 idle, 1 waiting for trigger, 2 summing
  longint m_ax, m_ay, m_cnt;
  longint e_x, e_y, e_n;
  bit     e_valid, e_busy, e_ovf;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      h_px[i] = 0; h_py[i] = 0; h_trig[i] = 0; h_mode[i] = 0;
    end
    m_state = 0; m_ax = 0; m_ay = 0; m_cnt = 0;
    e_x = 0; e_y = 0; e_n = 0; e_valid = 0; e_busy = 0; e_ovf = 0;
  endfunction

  function automatic longint clamp32(input longint v, output bit s);
    s = 1'b0;
    if (v > 64'sd2147483647) begin
      s = 1'b1;
      return 64'sd2147483647;
    end
    if (v < -64'sd2147483648) begin
      s = 1'b1;
      return -64'sd2147483648;
    end
    return v;
  endfunction

  function automatic void model_edge();
    longint px, py, sx, sy, nn;
    bit trg, chg, ovf_set, s1, s2;
    for (int i = 3; i > 0; i--) begin
      h_px[i] = h_px[i-1]; h_py[i] = h_py[i-1];
      h_trig[i] = h_trig[i-1]; h_mode[i] = h_mode[i-1];
    end
    h_mode[0] = mode;
    if (mode) begin
      h_trig[0] = square_trig;
      h_px[0] = sq_ref  ? longint'(sig_in) : -longint'(sig_in);
      h_py[0] = sq_quad ? longint'(sig_in) : -longint'(sig_in);
    end else begin
      h_trig[0] = harmonic_trig;
      h_px[0] = longint'(sig_in) * longint'(cos_ref);
      h_py[0] = longint'(sig_in) * longint'(sin_ref);
    end
    px = h_px[2]; py = h_py[2]; trg = h_trig[2];
    chg = (h_mode[2] != h_mode[3]);
    e_valid = 0;
    ovf_set = 0;
    if (!en) begin
      m_state = 0; m_ax = 0; m_ay = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (!chg && trg) m_state = 2;
    end else begin
      if (chg) begin
        m_state = 1; m_ax = 0; m_ay = 0; m_cnt = 0;
      end else begin
        sx = m_ax + px;
        sy = m_ay + py;
        if (m_cnt >= CNT_MAX) begin
          nn = CNT_MAX; ovf_set = 1;
        end else begin
          nn = m_cnt + 1;
        end
        if (trg) begin
          e_valid = 1;
          e_x = clamp32(sx >>> shift, s1);
          e_y = clamp32(sy >>> shift, s2);
          e_n = nn;
          if (s1 || s2) ovf_set = 1;
          m_ax = 0; m_ay = 0; m_cnt = 0;
        end else begin
          m_ax = sx; m_ay = sy; m_cnt = nn;
        end
      end
    end
    e_busy = (m_state == 2);
    if (ovf_set) e_ovf = 1;
    else if (clr) e_ovf = 0;
  endfunction

  // One clock: inputs are already applied; sample outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    if (valid === 1'b1) dut_valids++;
    check("valid", valid, e_valid);
    check("busy", busy, e_busy);
    check("ovf", ovf, e_ovf);
    check("x_out", x_out, e_x);
    check("y_out", y_out, e_y);
    check("n_samp", n_samp, e_n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, x_out, 0);
    check({tag, "_y"}, y_out, 0);
    check({tag, "_n"}, n_samp, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  int base;

  initial begin
    rstn = 1'b0; en = 1'b0; mode = 1'b0; shift = 5'd0; clr = 1'b0;
    sig_in = '0; cos_ref = '0; sin_ref = '0; harmonic_trig = 1'b0;
    sq_ref = 1'b0; sq_quad = 1'b0; square_trig = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    rstn = 1'b1;

    // Harmonic window of 8: first window discarded, then 800000 per window.
    en = 1'b1; mode = 1'b0; sig_in = 14'sd1000; cos_ref = 14'sd100; sin_ref = 14'sd0;
    base = dut_valids;
    for (int i = 0; i < 40; i++) begin
      harmonic_trig = (i % 8 == 7);
      cycle();
    end
    check("harm_x", x_out, 800000);
    check("harm_y", y_out, 0);
    check("harm_n", n_samp, 8);
    check("harm_windows", dut_valids - base, 3);

    // Square window of 8 with sq_ref high for the first half.
    mode = 1'b1; sig_in = -14'sd500; sq_quad = 1'b1; harmonic_trig = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sq_ref = ((i % 8) < 4);
      square_trig = (i % 8 == 7);
      cycle();
    end
    check("sq_x", x_out, 0);
    check("sq_y", y_out, -4000);
    check("sq_n", n_samp, 8);

    // Saturation over a 64-sample window, then clear, then shift by 2.
    mode = 1'b0; square_trig = 1'b0; sig_in = 14'sd8191; cos_ref = 14'sd8191;
    sin_ref = 14'sd0; shift = 5'd0;
    for (int i = 0; i < 330; i++) begin
      harmonic_trig = (i % 64 == 63);
      clr = (i == 200);
      if (i == 201) shift = 5'd2;
      cycle();
      if (i == 199) begin
        check("sat_x", x_out, 64'sd2147483647);
        check("sat_ovf", ovf, 1);
      end
      if (i == 200) check("clr_ovf", ovf, 0);
    end
    check("shift2_x", x_out, 1073479696);
    check("shift2_ovf", ovf, 0);

    // Enable drop mid-window: no valid until a fresh full window.
    shift = 5'd0; sig_in = 14'sd1000; cos_ref = 14'sd100; sin_ref = 14'sd50;
    for (int j = 0; j < 48; j++) begin
      harmonic_trig = (j % 8 == 7);
      en = (j != 20);
      if (j == 18) base = dut_valids;
      cycle();
      if (j == 20) check("drop_busy", busy, 0);
      if (j == 32) check("drop_novalid", dut_valids - base, 0);
    end
    en = 1'b1;
    check("drop_x", x_out, 800000);
    check("drop_y", y_out, 400000);

    // Mode toggled for two samples mid-window.
    for (int j = 0; j < 40; j++) begin
      harmonic_trig = (j % 8 == 7);
      mode = (j == 10 || j == 11);
      if (j == 10) base = dut_valids;
      cycle();
      if (j == 24) check("toggle_novalid", dut_valids - base, 0);
    end
    mode = 1'b0;
    check("toggle_x", x_out, 800000);
    check("toggle_n", n_samp, 8);

    // Asynchronous reset in the middle of a window.
    for (int j = 0; j < 13; j++) begin
      harmonic_trig = (j % 8 == 7);
      cycle();
    end
    #2 rstn = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 check_all_zero("held_rst");
    model_reset();
    rstn = 1'b1;
    for (int j = 0; j < 24; j++) begin
      harmonic_trig = (j % 8 == 7);
      cycle();
      if (j == 8) check("post_rst_sync", busy, 0);
      if (j == 9) check("post_rst_accum", busy, 1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sig_in  = 14'($urandom);
      cos_ref = 14'($urandom);
      sin_ref = 14'($urandom);
      sq_ref  = 1'($urandom);
      sq_quad = 1'($urandom);
      harmonic_trig = ($urandom_range(0, 4) == 0);
      square_trig   = ($urandom_range(0, 4) == 0);
      en   = ($urandom_range(0, 59) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0) shift = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
